address_queue: RTL
==================

ADDRESS_QUEUE -- requirements
Module: address_queue

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 2, width of every queued address; matches the downstream demultiplexor address width.
REQ-002 Parameter DEPTH, default 4, number of queue entries; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer offers in_addr this cycle.
REQ-006 in_addr  input  ADDRESS_WIDTH  target destination index.
REQ-007 in_ready  output  1  queue can accept an entry this cycle.
REQ-008 hold  input  1  downstream stall; no entry issued while high.
REQ-009 address  output  ADDRESS_WIDTH  registered destination index for the demultiplexor.
REQ-010 x  output  1  registered one-cycle issue strobe for the demultiplexor.
REQ-011 count  output  clog2(DEPTH+1)  current number of stored entries.

Function
REQ-012 Push: an entry is accepted at a rising edge where in_valid and in_ready are both 1.
REQ-013 in_ready is combinational, 1 exactly when count < DEPTH.
REQ-014 Full with simultaneous issue: in_ready stays 0, and a push is refused even if an entry is issued on the same edge.
REQ-015 Issue: on each rising edge where hold is 0 and count > 0, the oldest entry is removed, address loads it and x is 1 for the following cycle.
REQ-016 On an edge with hold 1 or count 0, x loads 0 and address keeps its previous value.
REQ-017 Ordering: strictly FIFO, so addresses are issued in acceptance order with no loss or duplication.
REQ-018 Latency: an entry accepted at edge k into an empty queue, with hold 0, drives x=1 after edge k+1, i.e. no same-edge bypass.
REQ-019 Simultaneous push and issue with 0 < count < DEPTH: both take effect and count is unchanged.
REQ-020 Push with in_valid=1 into an empty queue while hold=0: count becomes 1 at edge k and returns to 0 at edge k+1.
REQ-021 Read and write pointers wrap modulo DEPTH; count saturates neither above DEPTH nor below 0 by construction.
REQ-022 Sustained throughput: one issue per cycle while count > 0 and hold is 0.
REQ-023 x is never 1 for two cycles from a single entry; back-to-back 1s only occur for distinct queued entries.
REQ-024 in_addr is stored unmodified; all ADDRESS_WIDTH bits are significant.

Reset
REQ-025 While rst is 1, all state is cleared asynchronously: count 0, read and write pointers 0, address 0, x 0.
REQ-026 in_ready is 1 during reset because it follows count.
REQ-027 Reset mid-operation discards all queued entries, and the first issue after release carries only entries pushed after release.
REQ-028 Stored entry data need not be reset.

Structure
REQ-029 ADDRESS_WIDTH and DEPTH defaults and the count-width derivation live in a shared constants header used by address_queue and demultiplexor.
REQ-030 Storage and pointers are a sub-module, sync_fifo (ports clk, rst, push, pop, din, dout, count), and address_queue adds the issue register and hold logic.
REQ-031 Outputs address and x come directly from flops, with no combinational path from inputs.

Verification
REQ-032 Reset, push 2,0,3 on consecutive cycles with hold=0 -> x high three consecutive cycles with address 2,0,3, first strobe one cycle after the first push; count returns to 0.
REQ-033 hold=1, push 1,2,3,0 -> count=4 and in_ready=0; a fifth push of 1 is refused; release hold -> address 1,2,3,0 with x high four cycles, and the refused entry never appears.
REQ-034 Full queue, hold=0, in_valid=1 with in_addr=3 on the same edge -> one entry issued, push refused, count=3; next edge accepts 3 and count stays 3.
REQ-035 Count=2, push and issue every cycle for 10 cycles -> count remains 2, pointers wrap, issued sequence equals pushed sequence delayed by two entries.
REQ-036 Queue holding 3 entries, assert rst for one cycle mid-cycle (asynchronous) -> x=0, address=0, count=0 immediately; after release push 1 -> only address 1 issued.
REQ-037 Drive address and x into demultiplexor with ADDRESS_WIDTH=2 -> exactly one out bit high per strobe, matching the queued index.

Source files
------------

// File: rtl/address_queue_pkg.sv
// Shared constants for the address queue and the downstream demultiplexor:
// default address width, default depth and the count-width derivation.
package address_queue_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 2;
    localparam int DEFAULT_DEPTH         = 4;

    // count must represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/address_queue_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// Push is refused when full and pop is ignored when empty.
module sync_fifo
    import address_queue_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW   = count_width(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    // full refuses a push even when the same edge pops
    assign wr_en = push && (count != FULL);
    assign rd_en = pop && (count != '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !rd_en)
                count <= count + CW'(1);
            else if (!wr_en && rd_en)
                count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/address_queue.sv
// Address queue feeding a demultiplexor: FIFO of destination indices issued
// one per cycle as a registered address plus a one-cycle strobe x.
module address_queue
    import address_queue_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    localparam int CW           = count_width(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [ADDRESS_WIDTH-1:0] in_addr,
    output logic                     in_ready,
    input  logic                     hold,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     x,
    output logic [CW-1:0]            count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic                     push;
    logic                     pop;
    logic [ADDRESS_WIDTH-1:0] head;

    assign in_ready = (count != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = !hold && (count != '0);

    sync_fifo #(
        .WIDTH (ADDRESS_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (in_addr),
        .dout  (head),
        .count (count)
    );

    // head is read from storage, so a same-edge push never bypasses to issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address <= '0;
            x       <= 1'b0;
        end else begin
            x <= pop;
            if (pop)
                address <= head;
        end
    end

endmodule
